// File: rtl/sobel_window_gen.sv
// 3x3 window generator for the Sobel block: two line buffers plus a shift window, valid-mode output only.
// Optional SOBEL_WIN_SOF_EN adds an i_sof input that re-aligns the frame to pixel (0,0).
module sobel_window_gen #(
    parameter int unsigned NBIT        = 8,
    parameter int unsigned KERNEL_SIZE = 3,
    parameter int unsigned IMG_WIDTH   = 640,
    parameter int unsigned IMG_HEIGHT  = 480
) (
    input  logic                                           i_clk,
    input  logic                                           i_rst,
    input  logic [NBIT-1:0]                                i_pixel,
    input  logic                                           i_pixel_valid,
`ifdef SOBEL_WIN_SOF_EN
    input  logic                                           i_sof,
`endif
    output logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][NBIT-1:0] o_data,
    output logic                                           o_data_valid,
    output logic                                           o_frame_done
);

    localparam int unsigned COL_W = $clog2(IMG_WIDTH);
    localparam int unsigned ROW_W = $clog2(IMG_HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    generate
        if (KERNEL_SIZE != 3) begin : g_bad_kernel
            $error("sobel_window_gen: only KERNEL_SIZE=3 is supported");
        end
        if (IMG_WIDTH < 3 || IMG_HEIGHT < 3) begin : g_bad_image
            $error("sobel_window_gen: IMG_WIDTH and IMG_HEIGHT must be >= 3");
        end
    endgenerate

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d, state_cur;
    logic [COL_W-1:0] col_q, col_d, col_cur;
    logic [ROW_W-1:0] row_q, row_d, row_cur;
    logic             valid_d, done_d;
    logic             last_col, last_row;
    logic             restart;

    logic [NBIT-1:0] lb0 [IMG_WIDTH];
    logic [NBIT-1:0] lb1 [IMG_WIDTH];

`ifdef SOBEL_WIN_SOF_EN
    assign restart = i_pixel_valid & i_sof;
`else
    assign restart = 1'b0;
`endif

    // Start-of-frame forces the accepted pixel to be treated as (0,0) in FILL
    assign col_cur   = restart ? '0 : col_q;
    assign row_cur   = restart ? '0 : row_q;
    assign state_cur = restart ? FILL : state_q;
    assign last_col  = (col_cur == COL_LAST);
    assign last_row  = (row_cur == ROW_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= FILL;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        if (i_pixel_valid) begin
            col_d   = last_col ? '0 : col_cur + COL_W'(1);
            row_d   = row_cur;
            if (last_col) begin
                row_d = last_row ? '0 : row_cur + ROW_W'(1);
            end
            valid_d = (state_cur == RUN) && (col_cur >= COL_W'(2));
            done_d  = valid_d && last_col && last_row;
            state_d = state_cur;
            case (state_cur)
                FILL: if (last_col && row_cur == ROW_W'(1)) state_d = RUN;
                RUN:  if (last_col && last_row)             state_d = FILL;
                default: state_d = FILL;
            endcase
        end
    end

    // Line buffer RAM: no reset, contents before the first two lines are don't-care
    always_ff @(posedge i_clk) begin
        if (i_pixel_valid) begin
            lb1[col_cur] <= lb0[col_cur];
            lb0[col_cur] <= i_pixel;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_data       <= '0;
            o_data_valid <= 1'b0;
            o_frame_done <= 1'b0;
        end else begin
            o_data_valid <= valid_d;
            o_frame_done <= done_d;
            if (i_pixel_valid) begin
                for (int r = 0; r < int'(KERNEL_SIZE); r++) begin
                    for (int c = 0; c < int'(KERNEL_SIZE) - 1; c++) begin
                        o_data[r][c] <= o_data[r][c+1];
                    end
                end
                o_data[0][KERNEL_SIZE-1] <= lb1[col_cur];
                o_data[1][KERNEL_SIZE-1] <= lb0[col_cur];
                o_data[2][KERNEL_SIZE-1] <= i_pixel;
            end
        end
    end

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen: 5x4 image instance plus a minimal 3x3 image instance.
module tb_sobel_window_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst_a, va, dv_a, fd_a;
    logic [7:0]            px_a;
    logic [2:0][2:0][7:0]  data_a;
    logic                  rst_b, vb, dv_b, fd_b;
    logic [7:0]            px_b;
    logic [2:0][2:0][7:0]  data_b;
`ifdef SOBEL_WIN_SOF_EN
    logic                  sof_a, sof_b;
`endif

    int          n_vec   = 0;
    int          n_err   = 0;
    int          win_cnt = 0;
    int          fd_cnt  = 0;
    int          w0, f0;
    bit          gap_en  = 1'b0;
    logic        acc_a   = 1'b0;
    logic [71:0] prev_a  = '0;

    sobel_window_gen #(.NBIT(8), .KERNEL_SIZE(3), .IMG_WIDTH(5), .IMG_HEIGHT(4)) u_dut_a (
        .i_clk(clk), .i_rst(rst_a), .i_pixel(px_a), .i_pixel_valid(va),
`ifdef SOBEL_WIN_SOF_EN
        .i_sof(sof_a),
`endif
        .o_data(data_a), .o_data_valid(dv_a), .o_frame_done(fd_a));

    sobel_window_gen #(.NBIT(8), .KERNEL_SIZE(3), .IMG_WIDTH(3), .IMG_HEIGHT(3)) u_dut_b (
        .i_clk(clk), .i_rst(rst_b), .i_pixel(px_b), .i_pixel_valid(vb),
`ifdef SOBEL_WIN_SOF_EN
        .i_sof(sof_b),
`endif
        .o_data(data_b), .o_data_valid(dv_b), .o_frame_done(fd_b));

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Window whose bottom-right pixel is (r,c) in an image of width w with pixel = base + raster index
    function automatic logic [71:0] mk_win(input int base, input int r, input int c, input int w);
        logic [2:0][2:0][7:0] x;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                x[i][j] = 8'(base + (r - 2 + i) * w + (c - 2 + j));
        return x;
    endfunction

    function automatic logic [71:0] lit9(input int a, input int b, input int c, input int d,
                                         input int e, input int f, input int g, input int h,
                                         input int k);
        logic [2:0][2:0][7:0] x;
        x[0][0] = 8'(a); x[0][1] = 8'(b); x[0][2] = 8'(c);
        x[1][0] = 8'(d); x[1][1] = 8'(e); x[1][2] = 8'(f);
        x[2][0] = 8'(g); x[2][1] = 8'(h); x[2][2] = 8'(k);
        return x;
    endfunction

    // Count windows and, when enabled, check that idle cycles hold the outputs
    always @(posedge clk) acc_a <= va;
    always @(negedge clk) begin
        if (dv_a) win_cnt++;
        if (fd_a) fd_cnt++;
        if (gap_en && !acc_a) begin
            check("gap_valid", 72'(dv_a), 72'(0));
            check("gap_hold", data_a, prev_a);
        end
        prev_a <= data_a;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input int base, input int max_gap);
        for (int k = 0; k < 20; k++) begin
            automatic int r = k / 5;
            automatic int c = k % 5;
            px_a = 8'(base + k);
            va   = 1'b1;
            @(negedge clk);
            va = 1'b0;
`ifdef SOBEL_WIN_SOF_EN
            sof_a = 1'b0;
`endif
            if (r >= 2 && c >= 2) begin
                check($sformatf("valid_b%0d_p%0d", base, k), 72'(dv_a), 72'(1));
                check($sformatf("win_b%0d_p%0d", base, k), data_a, mk_win(base, r, c, 5));
            end else begin
                check($sformatf("novalid_b%0d_p%0d", base, k), 72'(dv_a), 72'(0));
            end
            check($sformatf("fdone_b%0d_p%0d", base, k), 72'(fd_a), 72'(k == 19));
            if (max_gap > 0) idle($urandom_range(0, max_gap));
        end
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; va = 1'b0; vb = 1'b0; px_a = '0; px_b = '0;
`ifdef SOBEL_WIN_SOF_EN
        sof_a = 1'b0; sof_b = 1'b0;
`endif
        idle(2);
        check("rst_data", data_a, 72'(0));
        check("rst_valid", 72'(dv_a), 72'(0));
        check("rst_fdone", 72'(fd_a), 72'(0));
        rst_a = 1'b0; rst_b = 1'b0;
        idle(1);

        // Single frame, continuous valid
        w0 = win_cnt; f0 = fd_cnt;
        send_frame(0, 0);
        idle(3);
        check("t1_windows", 72'(win_cnt - w0), 72'(6));
        check("t1_fdones", 72'(fd_cnt - f0), 72'(1));
        check("t1_last_win_held", data_a, lit9(7, 8, 9, 12, 13, 14, 17, 18, 19));

        // Same frame with random idle gaps
        w0 = win_cnt; f0 = fd_cnt;
        gap_en = 1'b1;
        send_frame(0, 3);
        idle(3);
        gap_en = 1'b0;
        check("t2_windows", 72'(win_cnt - w0), 72'(6));
        check("t2_fdones", 72'(fd_cnt - f0), 72'(1));

        // Two back-to-back frames
        w0 = win_cnt; f0 = fd_cnt;
        send_frame(0, 0);
        send_frame(100, 0);
        idle(3);
        check("t3_windows", 72'(win_cnt - w0), 72'(12));
        check("t3_fdones", 72'(fd_cnt - f0), 72'(2));
        check("t3_last_win_held", data_a, lit9(107, 108, 109, 112, 113, 114, 117, 118, 119));

        // Asynchronous reset mid-frame
        w0 = win_cnt; f0 = fd_cnt;
        for (int k = 0; k < 8; k++) begin
            px_a = 8'(k); va = 1'b1;
            @(negedge clk);
            va = 1'b0;
        end
        check("t4_prereset_nonzero", 72'(data_a != '0), 72'(1));
        @(posedge clk);
        #2 rst_a = 1'b1;
        #1;
        check("t4_async_data", data_a, 72'(0));
        check("t4_async_valid", 72'(dv_a), 72'(0));
        check("t4_async_fdone", 72'(fd_a), 72'(0));
        @(negedge clk);
        rst_a = 1'b0;
        send_frame(0, 0);
        idle(3);
        check("t4_windows", 72'(win_cnt - w0), 72'(6));
        check("t4_fdones", 72'(fd_cnt - f0), 72'(1));

        // Minimum 3x3 image: one window with frame done
        for (int k = 0; k < 9; k++) begin
            px_b = 8'(k); vb = 1'b1;
            @(negedge clk);
            vb = 1'b0;
            check($sformatf("t5_valid_p%0d", k), 72'(dv_b), 72'(k == 8));
            check($sformatf("t5_fdone_p%0d", k), 72'(fd_b), 72'(k == 8));
        end
        check("t5_window", data_b, lit9(0, 1, 2, 3, 4, 5, 6, 7, 8));

`ifdef SOBEL_WIN_SOF_EN
        // Partial frame abandoned by start-of-frame
        w0 = win_cnt; f0 = fd_cnt;
        for (int k = 0; k < 7; k++) begin
            px_a = 8'(50 + k); va = 1'b1;
            @(negedge clk);
            va = 1'b0;
        end
        sof_a = 1'b1;
        send_frame(0, 0);
        idle(3);
        check("t6_windows", 72'(win_cnt - w0), 72'(6));
        check("t6_fdones", 72'(fd_cnt - f0), 72'(1));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sobel_window_gen.md
Name: sobel_window_gen

Overview:
Producer side of the 3x3 window interface consumed by the Sobel convolution block. Accepts a raster-order pixel stream (one pixel per valid beat) and buffers two full image lines plus a 3x3 shift window. Emits one fully populated 3x3 window with a one-cycle valid strobe per interior pixel. Sits between the grayscale pixel source and conv_block_sobel.

Parameters:
NBIT, 8, pixel bit-width
KERNEL_SIZE, 3, window side; only 3 is supported; elaboration error otherwise
IMG_WIDTH, 640, pixels per line, >= 3
IMG_HEIGHT, 480, lines per frame, >= 3

Ports:
i_clk  input  1  clock, rising edge
i_rst  input  1  reset, asynchronous, active-high
i_pixel  input  NBIT  pixel data, raster order
i_pixel_valid  input  1  i_pixel accepted on this edge
o_data  output  NBIT x [KERNEL_SIZE][KERNEL_SIZE]  window, [r][c]; r=0 top (oldest line), c=0 left (oldest column)
o_data_valid  output  1  o_data holds a valid interior window; one-cycle pulse per window
o_frame_done  output  1  one-cycle pulse, coincident with the last window of a frame

Behaviour:
- Reset (async assert, sync release on i_clk): o_data all 0, o_data_valid 0, o_frame_done 0, col=0, row=0, state FILL. Line-buffer RAM not cleared; contents are don't-care.
- Line buffers: two IMG_WIDTH-deep NBIT memories, lb0 (line row-1) and lb1 (line row-2), indexed by col. On an accepted pixel: lb1[col]<=lb0[col], lb0[col]<=i_pixel.
- Window: on an accepted pixel, every window row shifts left by one column (c0<=c1, c1<=c2). New column c2: [0][2]<=lb1[col], [1][2]<=lb0[col], [2][2]<=i_pixel.
- No accepted pixel (i_pixel_valid=0): nothing advances; o_data holds; o_data_valid=0, o_frame_done=0. Gaps of any length are legal.
- Counters: col increments per accepted pixel and wraps IMG_WIDTH-1 -> 0 with row+1. row wraps IMG_HEIGHT-1 -> 0 at the last pixel of the frame.
- FSM: FILL (row<2) -> RUN when the pixel at (row 1, col IMG_WIDTH-1) is accepted. RUN -> FILL when the pixel at (IMG_HEIGHT-1, IMG_WIDTH-1) is accepted.
- o_data_valid is registered together with o_data. It is 1 in the cycle after acceptance of pixel (row,col) iff state=RUN and col>=2. Latency: 1 cycle from accepting the bottom-right pixel to the window at the output.
- Columns 0-1 of each line: the window contains previous-line wrap data and valid is suppressed.
- Windows per frame: (IMG_WIDTH-2)*(IMG_HEIGHT-2). No border padding; output is valid-mode only.
- o_frame_done=1 in the same cycle as the valid for the window ending at (IMG_HEIGHT-1, IMG_WIDTH-1).
- Back-to-back frames need no idle cycles. Rows 0-1 of the next frame produce no valid windows.
- Reset mid-frame: all counters and state return to reset values immediately. A partial window in flight is dropped with no valid pulse. The next accepted pixel is (0,0).
- No backpressure: downstream must accept every valid window.

Optional Feature:
Macro SOBEL_WIN_SOF_EN.
- Defined: adds port i_sof (input, 1, start of frame, sampled only with i_pixel_valid). An accepted pixel with i_sof=1 is treated as pixel (0,0): col and row are forced to 0 before update, state goes to FILL, and any partial frame is abandoned with no o_frame_done. i_sof=1 while already at (0,0) has no effect.
- Undefined: port absent; frame alignment comes from counting only.

Test Plan:
- IMG_WIDTH=5, IMG_HEIGHT=4, pixel = raster index 0..19, continuous valid -> exactly 6 valid windows. First window appears 1 cycle after pixel 12 is accepted: rows {0,1,2},{5,6,7},{10,11,12}. Last window rows {7,8,9},{12,13,14},{17,18,19} with o_frame_done=1.
- Same frame with pseudo-random 0-3 idle cycles between pixels -> identical 6-window sequence; o_data stable and o_data_valid=0 during gaps.
- Two back-to-back frames (frame 2 pixels = index+100) -> 12 windows total. No valid during frame 2 pixels 0-11. Frame 2 first window rows {100,101,102},{105,106,107},{110,111,112}.
- Assert i_rst asynchronously after 8 pixels, mid-clock -> outputs 0 immediately, no valid pulse. A following clean frame yields the same 6 windows as the first test.
- IMG_WIDTH=3, IMG_HEIGHT=3, pixels 0..8 -> single window {0,1,2},{3,4,5},{6,7,8} with o_data_valid=1 and o_frame_done=1 in the same cycle.
- With SOBEL_WIN_SOF_EN: send 7 pixels, then a full frame whose first pixel carries i_sof=1 -> 6 windows identical to the first test, no o_frame_done for the abandoned partial frame.
